// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared widths, itype encoding and ingress FIFO payload types
package mure_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_LEN  = 32;
    localparam int unsigned ITYPE_LEN = 3;
    localparam int unsigned CAUSE_LEN = 5;

    typedef enum logic [ITYPE_LEN-1:0] {
        ITYPE_STD       = 3'd0,
        ITYPE_EXC       = 3'd1,
        ITYPE_INT       = 3'd2,
        ITYPE_ERET      = 3'd3,
        ITYPE_NT_BR     = 3'd4,
        ITYPE_TK_BR     = 3'd5,
        ITYPE_UNINF_JMP = 3'd6
    } itype_e;

    // Per-lane payload of the uop ingress FIFOs.
    typedef struct packed {
        logic [XLEN-1:0]     iaddr;
        logic [INST_LEN-1:0] inst;
        itype_e              itype;
    } uop_entry_s;

    // Per-bundle trap record of the common ingress FIFO.
    typedef struct packed {
        logic                 exception;
        logic                 interrupt;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } common_entry_s;

endpackage

// File: rtl/mure_lane_picker.sv
// rtl/mure_lane_picker.sv - lowest/highest set lane of a retire mask
// Ports: mask_i (lane mask), lo_idx_o (lowest set lane), hi_idx_o (highest
// set lane), any_o (mask non-zero). Indices are 0 when the mask is empty.
module mure_lane_picker #(
    parameter int NrRetiredInstr = 2,
    localparam int IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1
) (
    input  logic [NrRetiredInstr-1:0] mask_i,
    output logic [IdxW-1:0]           lo_idx_o,
    output logic [IdxW-1:0]           hi_idx_o,
    output logic                      any_o
);

    always_comb begin
        lo_idx_o = '0;
        hi_idx_o = '0;
        for (int i = NrRetiredInstr - 1; i >= 0; i--) begin
            if (mask_i[i]) lo_idx_o = IdxW'(i);
        end
        for (int i = 0; i < NrRetiredInstr; i++) begin
            if (mask_i[i]) hi_idx_o = IdxW'(i);
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/mure_serializer.sv
// rtl/mure_serializer.sv - serializes multi-retirement bundles into single-retirement records
// Ingress: bundle_valid_i/bundle_pop_o plus per-lane valids/iaddr/inst/itype
// and one shared trap record (exception/interrupt/cause/tval).
// Egress: registered record (out_valid_o/ready_i handshake), busy_o while a
// bundle is partially emitted, retired_cnt_o counting accepted retirements.
module mure_serializer
    import mure_pkg::*;
#(
    parameter int NrRetiredInstr = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                bundle_valid_i,
    output logic                                bundle_pop_o,
    input  logic [NrRetiredInstr-1:0]           valids_i,
    input  logic [NrRetiredInstr*XLEN-1:0]      iaddr_i,
    input  logic [NrRetiredInstr*INST_LEN-1:0]  inst_i,
    input  logic [NrRetiredInstr*ITYPE_LEN-1:0] itype_i,
    input  logic                                exception_i,
    input  logic                                interrupt_i,
    input  logic [CAUSE_LEN-1:0]                cause_i,
    input  logic [XLEN-1:0]                     tval_i,
    input  logic                                ready_i,
    output logic                                out_valid_o,
    output logic                                iretired_o,
    output logic [XLEN-1:0]                     iaddr_o,
    output logic [INST_LEN-1:0]                 inst_data_o,
    output logic [ITYPE_LEN-1:0]                itype_o,
    output logic                                exception_o,
    output logic                                interrupt_o,
    output logic [CAUSE_LEN-1:0]                cause_o,
    output logic [XLEN-1:0]                     tval_o,
    output logic                                busy_o,
    output logic [15:0]                         retired_cnt_o
);

    localparam int IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e                    state_q, state_d;
    logic [NrRetiredInstr-1:0] done_mask_q, done_mask_d;
    logic                      out_valid_q, out_valid_d;
    logic                      iretired_q, iretired_d;
    uop_entry_s                uop_q, uop_d;
    common_entry_s             trap_q, trap_d;
    logic [15:0]               retired_cnt_q, retired_cnt_d;
    logic                      pop;

    logic [NrRetiredInstr-1:0] rem, cur_onehot;
    logic [IdxW-1:0]           cur_idx, last_idx;
    logic                      rem_any, adv, go, cur_is_last;
    uop_entry_s                cur_uop;
    common_entry_s             bundle_trap;

    assign rem = valids_i & ~done_mask_q;

    // Emitted lanes are always the lowest ones, so the highest set bit of rem
    // is the highest set bit of valids_i whenever rem is non-zero.
    mure_lane_picker #(
        .NrRetiredInstr (NrRetiredInstr)
    ) u_lane_picker (
        .mask_i   (rem),
        .lo_idx_o (cur_idx),
        .hi_idx_o (last_idx),
        .any_o    (rem_any)
    );

    assign adv         = ~out_valid_q | ready_i;
    assign go          = bundle_valid_i & adv;
    assign cur_is_last = (cur_idx == last_idx);
    assign bundle_trap = {exception_i, interrupt_i, cause_i, tval_i};

    always_comb begin
        cur_uop    = '0;
        cur_onehot = '0;
        for (int l = 0; l < NrRetiredInstr; l++) begin
            if (cur_idx == IdxW'(l)) begin
                cur_onehot[l] = 1'b1;
                cur_uop.iaddr = iaddr_i[l*XLEN +: XLEN];
                cur_uop.inst  = inst_i[l*INST_LEN +: INST_LEN];
                cur_uop.itype = itype_e'(itype_i[l*ITYPE_LEN +: ITYPE_LEN]);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        done_mask_d   = done_mask_q;
        out_valid_d   = out_valid_q;
        iretired_d    = iretired_q;
        uop_d         = uop_q;
        trap_d        = trap_q;
        pop           = 1'b0;
        // A record accepted in a flush cycle still counts.
        retired_cnt_d = retired_cnt_q + 16'(out_valid_q & ready_i & iretired_q);

        if (flush_i) begin
            state_d     = IDLE;
            done_mask_d = '0;
            out_valid_d = 1'b0;
        end else if (go) begin
            if (rem_any) begin
                out_valid_d = 1'b1;
                iretired_d  = 1'b1;
                uop_d       = cur_uop;
                trap_d      = cur_is_last ? bundle_trap : '0;
                pop         = cur_is_last;
                done_mask_d = cur_is_last ? '0 : (done_mask_q | cur_onehot);
                state_d     = cur_is_last ? IDLE : EMIT;
            end else if (exception_i | interrupt_i) begin
                // Trap with no retirement: a bare trap record.
                out_valid_d = 1'b1;
                iretired_d  = 1'b0;
                uop_d       = '0;
                trap_d      = bundle_trap;
                pop         = 1'b1;
                done_mask_d = '0;
                state_d     = IDLE;
            end else begin
                // Empty bundle: drop it; adv means any old record was taken.
                out_valid_d = 1'b0;
                pop         = 1'b1;
                done_mask_d = '0;
                state_d     = IDLE;
            end
        end else if (ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            done_mask_q   <= '0;
            out_valid_q   <= 1'b0;
            iretired_q    <= 1'b0;
            uop_q         <= '0;
            trap_q        <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            done_mask_q   <= done_mask_d;
            out_valid_q   <= out_valid_d;
            iretired_q    <= iretired_d;
            uop_q         <= uop_d;
            trap_q        <= trap_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // The pop strobe is combinational; keep it quiet while reset is held.
    assign bundle_pop_o  = pop & rst_ni;
    assign busy_o        = (state_q == EMIT);
    assign out_valid_o   = out_valid_q;
    assign iretired_o    = iretired_q;
    assign iaddr_o       = uop_q.iaddr;
    assign inst_data_o   = uop_q.inst;
    assign itype_o       = uop_q.itype;
    assign exception_o   = trap_q.exception;
    assign interrupt_o   = trap_q.interrupt;
    assign cause_o       = trap_q.cause;
    assign tval_o        = trap_q.tval;
    assign retired_cnt_o = retired_cnt_q;

    bundle_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (busy_o && !flush_i) |-> bundle_valid_i);

endmodule

// File: tb/tb_mure_serializer.sv
// tb/tb_mure_serializer.sv - self-checking bench for mure_serializer
module tb_mure_serializer;
    import mure_pkg::*;

    localparam int N = 2;

    logic            clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic            bundle_valid_i = 1'b0, bundle_pop_o;
    logic [N-1:0]    valids_i = '0;
    logic [N*32-1:0] iaddr_i = '0, inst_i = '0;
    logic [N*3-1:0]  itype_i = '0;
    logic            exception_i = 1'b0, interrupt_i = 1'b0;
    logic [4:0]      cause_i = '0;
    logic [31:0]     tval_i = '0;
    logic            ready_i = 1'b0;
    logic            out_valid_o, iretired_o, exception_o, interrupt_o, busy_o;
    logic [31:0]     iaddr_o, inst_data_o, tval_o;
    logic [2:0]      itype_o;
    logic [4:0]      cause_o;
    logic [15:0]     retired_cnt_o;

    always #5 clk_i = ~clk_i;

    mure_serializer #(.NrRetiredInstr(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .bundle_valid_i(bundle_valid_i), .bundle_pop_o(bundle_pop_o),
        .valids_i(valids_i), .iaddr_i(iaddr_i), .inst_i(inst_i), .itype_i(itype_i),
        .exception_i(exception_i), .interrupt_i(interrupt_i), .cause_i(cause_i),
        .tval_i(tval_i), .ready_i(ready_i), .out_valid_o(out_valid_o),
        .iretired_o(iretired_o), .iaddr_o(iaddr_o), .inst_data_o(inst_data_o),
        .itype_o(itype_o), .exception_o(exception_o), .interrupt_o(interrupt_o),
        .cause_o(cause_o), .tval_o(tval_o), .busy_o(busy_o),
        .retired_cnt_o(retired_cnt_o)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [31:0] iaddr;
        logic [31:0] inst;
        logic [2:0]  itype;
        logic        iretired;
        logic        exc;
        logic        irq;
        logic [4:0]  cause;
        logic [31:0] tval;
    } rec_t;

    rec_t exp_q[$];
    int   exp_cnt;

    // A bundle becomes one record per valid lane in lane order, the trap on the
    // final one; with no valid lane a trap still yields one bare record.
    function automatic void model_bundle(input logic [N-1:0] v, input logic [N*32-1:0] pcs,
                                         input logic [N*32-1:0] insts, input logic [N*3-1:0] its,
                                         input logic exc, input logic irq,
                                         input logic [4:0] cause, input logic [31:0] tval);
        int   last = -1;
        rec_t r;
        for (int l = 0; l < N; l++) if (v[l]) last = l;
        for (int l = 0; l < N; l++) begin
            if (v[l]) begin
                r = '0;
                r.iaddr = pcs[l*32 +: 32];
                r.inst  = insts[l*32 +: 32];
                r.itype = its[l*3 +: 3];
                r.iretired = 1'b1;
                if (l == last) begin
                    r.exc = exc; r.irq = irq; r.cause = cause; r.tval = tval;
                end
                exp_q.push_back(r);
                exp_cnt++;
            end
        end
        if (last < 0 && (exc || irq)) begin
            r = '0;
            r.exc = exc; r.irq = irq; r.cause = cause; r.tval = tval;
            exp_q.push_back(r);
        end
    endfunction

    function automatic rec_t cur_out();
        rec_t r;
        r.iaddr = iaddr_o; r.inst = inst_data_o; r.itype = itype_o;
        r.iretired = iretired_o; r.exc = exception_o; r.irq = interrupt_o;
        r.cause = cause_o; r.tval = tval_o;
        return r;
    endfunction

    bit   mon_en = 1'b0, hold_prev = 1'b0;
    rec_t held;

    always @(negedge clk_i) begin
        rec_t r;
        rec_t e;
        if (mon_en) begin
            r = cur_out();
            if (hold_prev) chk("hold_stable", {out_valid_o, r}, {1'b1, held});
            if (out_valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_record: got %0h expected none", r);
                end else begin
                    e = exp_q.pop_front();
                    chk("record", r, e);
                end
            end
            hold_prev = out_valid_o && !ready_i;
            held = r;
        end
    end

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [1:0]  valids;
        logic [31:0] pc0, pc1;
        logic        exc, irq;
        logic [4:0]  cause;
        logic [31:0] tval;
        int          n;
        logic [31:0] e_pc_first, e_pc_last;
        logic        e_ret_last;
    } vec_t;

    task automatic drive_bundle(input vec_t v);
        valids_i = v.valids; iaddr_i = {v.pc1, v.pc0};
        inst_i = {v.pc1 ^ 32'hA5A5_0000, v.pc0 ^ 32'hA5A5_0000};
        itype_i = {3'd5, 3'd0};
        exception_i = v.exc; interrupt_i = v.irq; cause_i = v.cause; tval_i = v.tval;
    endtask

    task automatic chk_rec(input string nm, input int r, input vec_t v);
        bit last = (r == v.n - 1);
        chk({nm, "_valid"}, out_valid_o, 1'b1);
        chk({nm, "_iaddr"}, iaddr_o, last ? v.e_pc_last : v.e_pc_first);
        chk({nm, "_iretired"}, iretired_o, last ? v.e_ret_last : 1'b1);
        chk({nm, "_trap"}, {exception_o, interrupt_o, cause_o, tval_o},
            last ? {v.exc, v.irq, v.cause, v.tval} : 39'd0);
    endtask

    // Runs one bundle under ready_i=1; starts and ends just after a rising edge.
    task automatic run_vec(input string nm, input vec_t v);
        int cyc = (v.n > 0) ? v.n : 1;
        drive_bundle(v);
        bundle_valid_i = 1'b1;
        ready_i = 1'b1;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk_i);
            chk({nm, "_pop"}, bundle_pop_o, (c == cyc - 1));
            if (c > 0) chk_rec(nm, c - 1, v);
            @(posedge clk_i); #1;
        end
        bundle_valid_i = 1'b0;
        if (v.n > 0) begin
            @(negedge clk_i);
            chk_rec(nm, v.n - 1, v);
            chk({nm, "_nopop"}, bundle_pop_o, 1'b0);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        chk({nm, "_idle"}, {out_valid_o, busy_o}, 2'b00);
        @(posedge clk_i); #1;
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [N-1:0]    rv;
        logic [N*32-1:0] rpc, rin;
        logic [N*3-1:0]  rit;
        logic            rexc, rirq, popped;
        logic [4:0]      rcause;
        logic [31:0]     rtval;
        int              n;

        tbl[0] = '{2'b11, 32'h100, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0,    2, 32'h100, 32'h104, 1'b1};
        tbl[1] = '{2'b10, 32'h0,   32'h104, 1'b1, 1'b0, 5'd2, 32'hDEAD, 1, 32'h0,   32'h104, 1'b1};
        tbl[2] = '{2'b00, 32'h500, 32'h504, 1'b0, 1'b1, 5'd7, 32'h55,   1, 32'h0,   32'h0,   1'b0};
        tbl[3] = '{2'b01, 32'h600, 32'h604, 1'b1, 1'b1, 5'd3, 32'h1234, 1, 32'h0,   32'h600, 1'b1};
        tbl[4] = '{2'b00, 32'h700, 32'h704, 1'b0, 1'b0, 5'd0, 32'h0,    0, 32'h0,   32'h0,   1'b0};
        tbl[5] = '{2'b11, 32'h800, 32'h804, 1'b1, 1'b0, 5'd5, 32'hBEEF, 2, 32'h800, 32'h804, 1'b1};

        // Reset state, with a bundle already offered.
        valids_i = 2'b11; bundle_valid_i = 1'b1; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_state", {out_valid_o, busy_o, bundle_pop_o, iretired_o, iaddr_o, inst_data_o,
            exception_o, interrupt_o, cause_o, tval_o, retired_cnt_o}, 0);
        @(posedge clk_i); #1;
        bundle_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);
        @(negedge clk_i);
        chk("table_cnt", retired_cnt_o, 16'd6);
        @(posedge clk_i); #1;

        // Back-pressure: lane 0 held four cycles, then lane 1.
        drive_bundle(tbl[0]); bundle_valid_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        chk("stall_first_pop", bundle_pop_o, 1'b0);
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("stall_hold", {out_valid_o, iaddr_o, bundle_pop_o}, {1'b1, 32'h100, 1'b0});
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("stall_release", {out_valid_o, iaddr_o, bundle_pop_o}, {1'b1, 32'h100, 1'b1});
        @(posedge clk_i); #1;
        bundle_valid_i = 1'b0;
        @(negedge clk_i);
        chk("stall_second", {out_valid_o, iaddr_o, bundle_pop_o}, {1'b1, 32'h104, 1'b0});
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("stall_cnt", {out_valid_o, retired_cnt_o}, {1'b0, 16'd8});
        @(posedge clk_i); #1;

        // Flush after lane 0 is emitted; flush wins over a pending pop.
        drive_bundle(tbl[0]); bundle_valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_nopop", {bundle_pop_o, busy_o, out_valid_o, iaddr_o}, {1'b0, 1'b1, 1'b1, 32'h100});
        @(posedge clk_i); #1;
        flush_i = 1'b0; bundle_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_clear", {out_valid_o, busy_o, bundle_pop_o, retired_cnt_o}, {3'b000, 16'd9});
        @(posedge clk_i); #1;
        v = '{2'b11, 32'h200, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0, 2, 32'h200, 32'h204, 1'b1};
        run_vec("flush_next", v);
        @(negedge clk_i);
        chk("flush_cnt", retired_cnt_o, 16'd11);
        @(posedge clk_i); #1;

        // Randomized bundles and back-pressure against the model.
        exp_cnt = 11;
        mon_en = 1'b1;
        for (int b = 0; b < 300; b++) begin
            rv = 2'($urandom_range(0, 3));
            rpc = {$urandom, $urandom};
            rin = {$urandom, $urandom};
            rit = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 6))};
            rexc = ($urandom_range(0, 3) == 0);
            rirq = ($urandom_range(0, 4) == 0);
            rcause = 5'($urandom);
            rtval = $urandom;
            valids_i = rv; iaddr_i = rpc; inst_i = rin; itype_i = rit;
            exception_i = rexc; interrupt_i = rirq; cause_i = rcause; tval_i = rtval;
            model_bundle(rv, rpc, rin, rit, rexc, rirq, rcause, rtval);
            bundle_valid_i = 1'b1;
            n = 0;
            popped = 1'b0;
            while (!popped && n < 40) begin
                ready_i = ($urandom_range(0, 3) != 0);
                @(negedge clk_i);
                popped = bundle_pop_o;
                @(posedge clk_i); #1;
                n++;
            end
            chk("rand_pop_seen", popped, 1'b1);
            bundle_valid_i = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                ready_i = ($urandom_range(0, 1) == 0);
                @(posedge clk_i); #1;
            end
        end
        ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        @(negedge clk_i);
        chk("rand_all_emitted", exp_q.size(), 0);
        chk("rand_cnt", retired_cnt_o, exp_cnt & 16'hFFFF);
        @(posedge clk_i); #1;

        // Asynchronous reset in the middle of a bundle.
        drive_bundle(tbl[0]); bundle_valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", {out_valid_o, busy_o, iaddr_o, retired_cnt_o, bundle_pop_o,
            exception_o, iretired_o}, 0);
        @(posedge clk_i); #1;
        bundle_valid_i = 1'b0;
        #2;
        rst_ni = 1'b1;

        // 65537 accepted retirements: 32768 two-lane bundles then one single-lane.
        @(posedge clk_i); #1;
        valids_i = 2'b11; bundle_valid_i = 1'b1; ready_i = 1'b1;
        repeat (65536) @(posedge clk_i);
        #1;
        valids_i = 2'b01;
        @(posedge clk_i); #1;
        bundle_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("wrap_cnt", {out_valid_o, retired_cnt_o}, {1'b0, 16'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
